// File: rtl/layer6_actbuf_pingpong_ctrl_pkg.sv
// Shared types and default geometry for the Layer6 activation-buffer ping-pong controller.
package layer6_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  localparam int AWIDTH_DEF      = 15;
  localparam int DWIDTH_DEF      = 8;
  localparam int FRAME_WORDS_DEF = 32768;
  localparam int CNTW_DEF        = 16;

endpackage

// File: rtl/layer6_actbuf_pingpong_ctrl_if.sv
// Writer, PE, SyncSig and BRAM-side signals of the ping-pong controller in one bundle.
interface layer6_actbuf_pingpong_ctrl_if
  import layer6_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CNTW   = CNTW_DEF
);
  logic [AWIDTH-1:0] wr_address;
  logic              wr_ce;
  logic              wr_we;
  logic [DWIDTH-1:0] wr_d;
  logic              wr_grant;
  logic [AWIDTH-1:0] rd_address;
  logic              rd_ce;
  logic [DWIDTH-1:0] rd_q;
  logic              rd_done;
  logic              SyncSig_V;
  logic              SyncSig_V_ap_vld;
  logic              SyncSig_V_ap_ack;
  logic [AWIDTH:0]   bram_addr1;
  logic              bram_ce1;
  logic              bram_we1;
  logic [DWIDTH-1:0] bram_d1;
  logic [AWIDTH:0]   bram_addr0;
  logic              bram_ce0;
  logic [DWIDTH-1:0] bram_q0;
  logic [CNTW-1:0]   frames_written;
  logic [CNTW-1:0]   frames_read;
  logic              err_wr_drop;

  modport slave (
    input  wr_address, wr_ce, wr_we, wr_d, rd_address, rd_ce, rd_done,
           SyncSig_V_ap_ack, bram_q0,
    output wr_grant, rd_q, SyncSig_V, SyncSig_V_ap_vld,
           bram_addr1, bram_ce1, bram_we1, bram_d1, bram_addr0, bram_ce0,
           frames_written, frames_read, err_wr_drop
  );

  modport master (
    output wr_address, wr_ce, wr_we, wr_d, rd_address, rd_ce, rd_done,
           SyncSig_V_ap_ack, bram_q0,
    input  wr_grant, rd_q, SyncSig_V, SyncSig_V_ap_vld,
           bram_addr1, bram_ce1, bram_we1, bram_d1, bram_addr0, bram_ce0,
           frames_written, frames_read, err_wr_drop
  );
endinterface

// File: rtl/layer6_actbuf_pingpong_ctrl_bank_state.sv
// Ownership FSM of one ActBuf bank: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module actbuf_bank_state
  import layer6_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_start,
  input  logic        fill_end,
  input  logic        take,
  input  logic        drain_done,
  output bank_state_t state
);

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY:    if (fill_start) state <= fill_end ? FULL : FILLING;
        FILLING:  if (fill_end)   state <= FULL;
        FULL:     if (take)       state <= DRAINING;
        DRAINING: if (drain_done) state <= EMPTY;
        default:                  state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/layer6_actbuf_pingpong_ctrl.sv
// Ping-pong scheduler: splits the ActBuf BRAM into two banks, arbitrates writer/PE ownership,
// drives the SyncSig valid/ack handshake and counts completed frames.
module layer6_actbuf_pingpong_ctrl
  import layer6_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int DWIDTH      = DWIDTH_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int CNTW        = CNTW_DEF
) (
  input logic                          ap_clk,
  input logic                          ap_rst,
  layer6_actbuf_pingpong_ctrl_if.slave bus
);

  localparam logic [AWIDTH:0] LAST_WORD = (AWIDTH+1)'(FRAME_WORDS - 1);

  bank_state_t       bank_st [0:1];
  bank_state_t       wr_state, rd_state;
  logic              wr_ptr, rd_ptr;
  logic [AWIDTH:0]   wcnt;
  logic [CNTW-1:0]   frames_written_q, frames_read_q;
  logic              err_q, vld_q, sync_q;
  logic              grant, wr_stb, wr_acc, wr_last, take, rd_release;
  logic [1:0]        fill_start, fill_end, take_v, drain_v;

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    wr_state   = bank_st[wr_ptr];
    rd_state   = bank_st[rd_ptr];
    grant      = (wr_state == EMPTY) || (wr_state == FILLING);
    wr_stb     = bus.wr_ce & bus.wr_we;
    wr_acc     = wr_stb & grant & ~ap_rst;
    wr_last    = wr_acc && (wcnt == LAST_WORD);
    take       = vld_q & bus.SyncSig_V_ap_ack;
    rd_release = bus.rd_done && (rd_state == DRAINING);
    fill_start = '0;
    fill_end   = '0;
    take_v     = '0;
    drain_v    = '0;
    fill_start[wr_ptr] = wr_acc && (wr_state == EMPTY);
    fill_end[wr_ptr]   = wr_last;
    take_v[rd_ptr]     = take;
    drain_v[rd_ptr]    = rd_release;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    actbuf_bank_state u_state (
      .clk        (ap_clk),
      .rst        (ap_rst),
      .fill_start (fill_start[b]),
      .fill_end   (fill_end[b]),
      .take       (take_v[b]),
      .drain_done (drain_v[b]),
      .state      (bank_st[b])
    );
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      wcnt             <= '0;
      frames_written_q <= '0;
      frames_read_q    <= '0;
      err_q            <= 1'b0;
      vld_q            <= 1'b0;
      sync_q           <= 1'b0;
    end else begin
      if (wr_acc) wcnt <= wr_last ? '0 : wcnt + (AWIDTH+1)'(1);
      if (wr_last) begin
        wr_ptr           <= ~wr_ptr;
        frames_written_q <= frames_written_q + CNTW'(1);
      end
      if (rd_release) begin
        rd_ptr        <= ~rd_ptr;
        frames_read_q <= frames_read_q + CNTW'(1);
      end
      if (wr_stb && !grant) err_q <= 1'b1;
      // The offer is withdrawn in the ack cycle itself so vld never lingers a second cycle.
      vld_q  <= (rd_state == FULL) && !take;
      sync_q <= rd_ptr;
    end
  end

  assign bus.wr_grant         = grant;
  assign bus.bram_addr1       = {wr_ptr, bus.wr_address};
  assign bus.bram_ce1         = bus.wr_ce & grant & ~ap_rst;
  assign bus.bram_we1         = bus.wr_we & grant & ~ap_rst;
  assign bus.bram_d1          = bus.wr_d;
  assign bus.bram_addr0       = {rd_ptr, bus.rd_address};
  assign bus.bram_ce0         = bus.rd_ce && (rd_state == DRAINING) && !ap_rst;
  assign bus.rd_q             = bus.bram_q0;
  assign bus.SyncSig_V_ap_vld = vld_q;
  assign bus.SyncSig_V        = sync_q;
  assign bus.frames_written   = frames_written_q;
  assign bus.frames_read      = frames_read_q;
  assign bus.err_wr_drop      = err_q;

  logic [CNTW-1:0] frame_diff;
  assign frame_diff = frames_written_q - frames_read_q;

  a_frame_balance: assert property (@(posedge ap_clk) disable iff (ap_rst)
                                    frame_diff <= CNTW'(2));

endmodule

// File: doc/layer6_actbuf_pingpong_ctrl.md
Name: layer6_actbuf_pingpong_ctrl

Overview:
Ping-pong bank scheduler for the Layer6 activation buffer. It splits a double-depth ActBuf BRAM into two banks so the activation writer can fill one frame while the PE drains the other. It grants bank ownership and prepends the bank bit to both BRAM addresses. It also drives the SyncSig valid/ack handshake toward the PE and counts frames.

Parameters:
AWIDTH, 15, per-bank address width; physical BRAM address is AWIDTH+1 bits.
DWIDTH, 8, activation word width.
FRAME_WORDS, 32768, writes per frame; range 1..2^AWIDTH.
CNTW, 16, width of frame counters.

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous, active-high reset
wr_address  in  AWIDTH  writer BRAM address (bank-relative)
wr_ce  in  1  writer chip enable
wr_we  in  1  writer write enable
wr_d  in  DWIDTH  writer data
wr_grant  out  1  writer may write; the current write bank is EMPTY or FILLING
rd_address  in  AWIDTH  PE read address (bank-relative)
rd_ce  in  1  PE read enable
rd_q  out  DWIDTH  read data to PE (BRAM q0 passthrough)
rd_done  in  1  one-cycle pulse: PE finished the frame in its bank
SyncSig_V  out  1  index of the bank offered to the PE
SyncSig_V_ap_vld  out  1  a FULL bank is offered
SyncSig_V_ap_ack  in  1  PE accepts the offered bank
bram_addr1, bram_ce1, bram_we1, bram_d1  out  AWIDTH+1,1,1,DWIDTH  BRAM write port
bram_addr0, bram_ce0  out  AWIDTH+1,1  BRAM read port
bram_q0  in  DWIDTH  BRAM read data
frames_written, frames_read  out  CNTW,CNTW  wrapping frame counters
err_wr_drop  out  1  sticky: a write arrived while wr_grant was low

Behaviour:
- Per-bank 2-bit state: EMPTY, FILLING, FULL, DRAINING. Controller also holds wr_ptr, rd_ptr and an AWIDTH+1-bit write-word counter wcnt.
- Reset (also mid-frame): both banks EMPTY, wr_ptr=rd_ptr=0, wcnt=0, counters=0, err_wr_drop=0.
- Output values after reset: SyncSig_V_ap_vld=0, SyncSig_V=0, wr_grant=1. All BRAM enables are gated low while ap_rst is high.
- Write strobe = wr_ce & wr_we.
  - Accepted when wr_grant=1. bram_addr1={wr_ptr,wr_address} and bram_we1=1 combinationally, i.e. the write lands in the same cycle.
  - The first accepted write moves the bank EMPTY->FILLING and increments wcnt.
  - An accepted write with wcnt==FRAME_WORDS-1 moves the bank to FULL, clears wcnt, toggles wr_ptr and increments frames_written.
- Strobe with wr_grant=0: bram_ce1/we1 are forced to 0, the data is dropped, err_wr_drop is set. err_wr_drop clears only on reset.
- wr_grant = (state[wr_ptr]==EMPTY or FILLING). Combinational, so it drops the cycle after the last write of a frame if the other bank is not EMPTY.
- Reader handshake:
  - SyncSig_V_ap_vld = (state[rd_ptr]==FULL) and SyncSig_V = rd_ptr. Both are registered and update one cycle after the state change.
  - vld and SyncSig_V stay stable until ack.
  - vld & ack moves the bank to DRAINING; vld drops next cycle.
  - Ack without vld is ignored.
- Reads: bram_addr0={rd_ptr,rd_address}, bram_ce0=rd_ce only while state[rd_ptr]==DRAINING, else 0. rd_q=bram_q0 with 1-cycle BRAM latency.
- rd_done while DRAINING moves the bank to EMPTY, toggles rd_ptr and increments frames_read. rd_done in any other state is ignored.
- Simultaneous events on different banks (write-complete and rd_done, or write-complete and ack) are both applied in the same cycle.
- A bank that becomes EMPTY via rd_done may grant the writer the next cycle.
- Counters wrap modulo 2^CNTW.
- Invariant: at most one bank FILLING and at most one DRAINING. The assertion-checked invariant is frames_written - frames_read ∈ {0,1,2} (mod 2^CNTW).

Decomposition:
- Shared package layer6_pkg: bank-state enum (EMPTY=0, FILLING=1, FULL=2, DRAINING=3) and the AWIDTH/DWIDTH/FRAME_WORDS defaults.
- One natural sub-module, actbuf_bank_state: a single bank's 4-state FSM with inputs fill_start, fill_end, take, release. Instantiated twice. The top level holds the pointers, wcnt, address muxing and counters.

Test Plan:
- Reset, then 4 writes with FRAME_WORDS=4 -> bank0 FULL; SyncSig_V_ap_vld=1 and SyncSig_V=0 one cycle later; frames_written=1; wr_grant stays 1 (bank1 EMPTY); 5th write lands at bram_addr1=0x8000.
- Fill both banks without PE ack -> wr_grant=0; a 9th write -> bram_we1=0, err_wr_drop=1 sticky.
- ack bank0, read address 3 -> bram_addr0=0x0003, rd_q equals written data 1 cycle later. rd_done -> frames_read=1, rd_ptr=1, vld=1 with SyncSig_V=1 next cycle.
- Same cycle: last write of bank1 and rd_done of bank0 -> bank1 FULL, bank0 EMPTY, both counters increment, no lost event.
- Assert ap_rst mid-frame (wcnt=2, bank1 DRAINING) -> all states EMPTY, vld=0, counters 0, wr_grant=1 next cycle.
- Spurious rd_done and ack with no FULL/DRAINING bank -> no state or counter change.
